// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IFU/LSU request-response channels plus the single memory port
// slave: arbiter view; master: requesters and memory model view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_req_addr;
  logic                  ifu_resp_valid;
  logic                  ifu_resp_ready;
  logic [DATA_W-1:0]     ifu_resp_data;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_req_addr;
  logic                  lsu_req_wen;
  logic [DATA_W-1:0]     lsu_req_wdata;
  logic [DATA_W/8-1:0]   lsu_req_wmask;
  logic                  lsu_resp_valid;
  logic                  lsu_resp_ready;
  logic [DATA_W-1:0]     lsu_resp_data;

  logic                  mem_ren;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rvalid;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    input  mem_rdata, mem_rvalid,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_ren, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    output mem_rdata, mem_rvalid,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_ren, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter serialising one transaction at a time onto the memory port
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed LSU-over-IFU priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q;
  logic                id_lsu_q;
  logic                wen_q;
  logic                mem_ren_q;
  logic                mem_wen_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;
  logic                ifu_resp_valid_q;
  logic                lsu_resp_valid_q;
  logic [DATA_W-1:0]   resp_data_q;

  logic                lsu_pref;
  logic                lsu_win;
  logic                ifu_hs;
  logic                lsu_hs;
  logic                lsu_wr_hs;
  logic                resp_hs;

`ifdef MEM_ARB_RR_EN
  logic last_lsu_q;
  logic last_lsu_d;

  assign lsu_pref   = !last_lsu_q;
  assign last_lsu_d = lsu_hs ? 1'b1 : (ifu_hs ? 1'b0 : last_lsu_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_lsu_q <= 1'b1;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end
`else
  assign lsu_pref = 1'b1;
`endif

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign lsu_win           = bus.lsu_req_valid && (!bus.ifu_req_valid || lsu_pref);
  assign bus.lsu_req_ready = reset && (state_q == IDLE) && lsu_win;
  assign bus.ifu_req_ready = reset && (state_q == IDLE) && bus.ifu_req_valid && !lsu_win;

  assign lsu_hs    = bus.lsu_req_valid && bus.lsu_req_ready;
  assign ifu_hs    = bus.ifu_req_valid && bus.ifu_req_ready;
  assign lsu_wr_hs = lsu_hs && bus.lsu_req_wen;
  assign resp_hs   = (ifu_resp_valid_q && bus.ifu_resp_ready) ||
                     (lsu_resp_valid_q && bus.lsu_resp_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      id_lsu_q         <= 1'b0;
      wen_q            <= 1'b0;
      mem_ren_q        <= 1'b0;
      mem_wen_q        <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      resp_data_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_hs || ifu_hs) begin
            id_lsu_q    <= lsu_hs;
            wen_q       <= lsu_wr_hs;
            mem_addr_q  <= lsu_hs ? bus.lsu_req_addr : bus.ifu_req_addr;
            mem_ren_q   <= !lsu_wr_hs;
            mem_wen_q   <= lsu_wr_hs;
            mem_wdata_q <= lsu_wr_hs ? bus.lsu_req_wdata : '0;
            mem_wmask_q <= lsu_wr_hs ? bus.lsu_req_wmask : '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_ren_q   <= 1'b0;
          mem_wen_q   <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_wmask_q <= '0;
          resp_data_q <= '0;
          if (wen_q) begin
            lsu_resp_valid_q <= id_lsu_q;
            ifu_resp_valid_q <= !id_lsu_q;
            state_q          <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            resp_data_q      <= bus.mem_rdata;
            lsu_resp_valid_q <= id_lsu_q;
            ifu_resp_valid_q <= !id_lsu_q;
            state_q          <= RESP;
          end
        end
        RESP: begin
          if (resp_hs) begin
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            resp_data_q      <= '0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_ren        = mem_ren_q;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wmask      = mem_wmask_q;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.ifu_resp_data  = ifu_resp_valid_q ? resp_data_q : '0;
  assign bus.lsu_resp_data  = lsu_resp_valid_q ? resp_data_q : '0;
endmodule
